// File: rtl/dht_responder.sv
// Single-wire humidity/temperature sensor responder.
// Waits for a host start pulse on the open-drain data line, then sends the 40-bit frame
// {humi_int, humi_dec, temp_int, temp_dec, checksum}, MSB first.
// All phase lengths are microsecond counts scaled by TICKS_PER_US.
module dht_responder #(
  parameter int unsigned TICKS_PER_US  = 100,
  parameter int unsigned START_MIN_US  = 18000,
  parameter int unsigned RESP_DELAY_US = 30
) (
  input  logic       I_clk,
  input  logic       I_rst_n,
  input  logic       I_sda_in,
  output logic       O_sda_oe,
  input  logic [7:0] I_humi_int,
  input  logic [7:0] I_humi_dec,
  input  logic [7:0] I_temp_int,
  input  logic [7:0] I_temp_dec,
  output logic       O_busy,
  output logic       O_done
);

  localparam int unsigned StartTicks = START_MIN_US * TICKS_PER_US;
  localparam int unsigned DelayTicks = RESP_DELAY_US * TICKS_PER_US;
  localparam int unsigned RespTicks  = 80 * TICKS_PER_US;
  // The counter must hold the start threshold and every response phase.
  localparam int unsigned MaxA       = (StartTicks > DelayTicks) ? StartTicks : DelayTicks;
  localparam int unsigned MaxTicks   = (MaxA > RespTicks) ? MaxA : RespTicks;
  localparam int unsigned CntW       = $clog2(MaxTicks + 1);

  localparam logic [CntW-1:0] StartM1 = CntW'(StartTicks - 1);
  localparam logic [CntW-1:0] DelayN  = CntW'(DelayTicks);
  localparam logic [CntW-1:0] RespN   = CntW'(RespTicks);
  localparam logic [CntW-1:0] BitLowN = CntW'(50 * TICKS_PER_US);
  localparam logic [CntW-1:0] Bit0N   = CntW'(26 * TICKS_PER_US);
  localparam logic [CntW-1:0] Bit1N   = CntW'(70 * TICKS_PER_US);
  localparam logic [CntW-1:0] EndN    = CntW'(50 * TICKS_PER_US);

  typedef enum logic [3:0] {
    StIdle,
    StHostLow,
    StWaitRel,
    StRespDelay,
    StRespLow,
    StRespHigh,
    StBitLow,
    StBitHigh,
    StEndLow
  } state_e;

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic [5:0]        bit_cnt_q;
  logic [39:0]       shift_q;
  logic              oe_q, busy_q, done_q;
  logic              sda_meta_q, sda_sync_q, sda_prev_q;
  logic [CntW-1:0]   phase_len;
  logic              phase_end;
  logic              line, line_fall;
  logic [7:0]        checksum;

  assign line      = sda_sync_q;
  assign line_fall = sda_prev_q & ~sda_sync_q;
  assign checksum  = I_humi_int + I_humi_dec + I_temp_int + I_temp_dec;

  // Two-flop synchronizer plus one delayed copy for edge detection; idles high like the bus.
  always_ff @(posedge I_clk) begin
    if (!I_rst_n) begin
      sda_meta_q <= 1'b1;
      sda_sync_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      sda_meta_q <= I_sda_in;
      sda_sync_q <= sda_meta_q;
      sda_prev_q <= sda_sync_q;
    end
  end

  // Length of the current timed response phase, in clock cycles.
  always_comb begin
    phase_len = RespN;
    case (state_q)
      StRespDelay: phase_len = DelayN;
      StBitLow:    phase_len = BitLowN;
      StBitHigh:   phase_len = shift_q[39] ? Bit1N : Bit0N;
      StEndLow:    phase_len = EndN;
      default:     phase_len = RespN;
    endcase
  end

  assign phase_end = (cnt_q == phase_len - CntW'(1));

  // Main sequencer with registered line drive, busy and done.
  always_ff @(posedge I_clk) begin
    if (!I_rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      oe_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (line_fall) begin
            state_q <= StHostLow;
            cnt_q   <= '0;
          end
        end
        StHostLow: begin
          // Threshold wins over a same-cycle release so exactly START_MIN_US of low is accepted.
          if (cnt_q == StartM1) begin
            state_q <= StWaitRel;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
          end else if (line) begin
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StWaitRel: begin
          if (line) begin
            shift_q   <= {I_humi_int, I_humi_dec, I_temp_int, I_temp_dec, checksum};
            bit_cnt_q <= '0;
            cnt_q     <= '0;
            state_q   <= StRespDelay;
          end
        end
        StRespDelay, StRespLow, StRespHigh, StBitLow, StBitHigh, StEndLow: begin
          if (!phase_end) begin
            cnt_q <= cnt_q + CntW'(1);
          end else begin
            cnt_q <= '0;
            unique case (state_q)
              StRespDelay: begin state_q <= StRespLow;  oe_q <= 1'b1; end
              StRespLow:   begin state_q <= StRespHigh; oe_q <= 1'b0; end
              StRespHigh:  begin state_q <= StBitLow;   oe_q <= 1'b1; end
              StBitLow:    begin state_q <= StBitHigh;  oe_q <= 1'b0; end
              StBitHigh: begin
                shift_q   <= {shift_q[38:0], 1'b0};
                bit_cnt_q <= bit_cnt_q + 6'd1;
                oe_q      <= 1'b1;
                state_q   <= (bit_cnt_q == 6'd39) ? StEndLow : StBitLow;
              end
              default: begin
                state_q <= StIdle;
                oe_q    <= 1'b0;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end
            endcase
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign O_sda_oe = oe_q;
  assign O_busy   = busy_q;
  assign O_done   = done_q;

endmodule

// File: tb/tb_dht_responder.sv
// Directed bench for dht_responder with fast timing (2 ticks/us, 20 us start, 30 us delay).
module tb_dht_responder;

  logic       I_clk = 1'b0;
  logic       I_rst_n = 1'b0;
  logic       I_sda_in;
  logic       O_sda_oe;
  logic [7:0] I_humi_int = 8'h00;
  logic [7:0] I_humi_dec = 8'h00;
  logic [7:0] I_temp_int = 8'h00;
  logic [7:0] I_temp_dec = 8'h00;
  logic       O_busy;
  logic       O_done;

  logic       host_low = 1'b0;
  int         checks = 0;
  int         failures = 0;
  int         done_cnt = 0;

  // Open-drain bus with pull-up: low if either side drives.
  assign I_sda_in = ~(host_low | (O_sda_oe === 1'b1));

  always #5 I_clk = ~I_clk;

  always @(posedge I_clk) if (O_done === 1'b1) done_cnt <= done_cnt + 1;

  dht_responder #(
    .TICKS_PER_US (2),
    .START_MIN_US (20),
    .RESP_DELAY_US(30)
  ) dut (
    .I_clk     (I_clk),
    .I_rst_n   (I_rst_n),
    .I_sda_in  (I_sda_in),
    .O_sda_oe  (O_sda_oe),
    .I_humi_int(I_humi_int),
    .I_humi_dec(I_humi_dec),
    .I_temp_int(I_temp_int),
    .I_temp_dec(I_temp_dec),
    .O_busy    (O_busy),
    .O_done    (O_done)
  );

  task automatic host_start(input int low_cyc);
    @(negedge I_clk);
    host_low = 1'b1;
    repeat (low_cyc) @(negedge I_clk);
    host_low = 1'b0;
  endtask

  task automatic measure_run(input logic lvl, output int len);
    len = 0;
    while (O_sda_oe === lvl && len < 400) begin
      @(posedge I_clk); #1;
      len++;
    end
  endtask

  task automatic wait_oe_high(output int lat);
    lat = 0;
    while (O_sda_oe !== 1'b1 && lat < 300) begin
      @(posedge I_clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    I_rst_n = 1'b0;
    repeat (3) @(posedge I_clk);
    #1;
    checks++; if (O_sda_oe !== 1'b0) begin failures++; $display("FAIL reset_oe got=%b exp=0", O_sda_oe); end
    checks++; if (O_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", O_busy); end
    checks++; if (O_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", O_done); end
    @(negedge I_clk);
    I_rst_n = 1'b1;
    repeat (5) @(negedge I_clk);
  endtask

  task automatic test_glitch;
    bit seen_oe = 0;
    bit seen_busy = 0;
    host_start(30);
    repeat (300) begin
      @(posedge I_clk); #1;
      if (O_sda_oe !== 1'b0) seen_oe = 1;
      if (O_busy !== 1'b0) seen_busy = 1;
    end
    checks++; if (seen_oe) begin failures++; $display("FAIL glitch_oe got=asserted exp=never"); end
    checks++; if (seen_busy) begin failures++; $display("FAIL glitch_busy got=asserted exp=never"); end
  endtask

  // mode 0: plain; mode 1: bytes cleared during bit 10; mode 2: host pulls low in RESP_HIGH.
  task automatic run_frame(input string name, input int low_cyc, input int exp_lat,
                           input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                           input logic [7:0] b3, input logic [7:0] exp_ck, input int mode);
    int lo[42];
    int hi[41];
    int lat, d0, bad_lo, bad_hi, total, exp_total;
    logic [39:0] exp_bits;
    logic [39:0] rx;
    I_humi_int = b0; I_humi_dec = b1; I_temp_int = b2; I_temp_dec = b3;
    exp_bits = {b0, b1, b2, b3, exp_ck};
    d0 = done_cnt;
    host_start(low_cyc);
    wait_oe_high(lat);
    checks++;
    if (O_sda_oe !== 1'b1) begin
      failures++; $display("FAIL %s_start got=no_response exp=oe_high", name);
      return;
    end
    if (exp_lat != 0) begin
      checks++;
      if (lat != exp_lat) begin failures++; $display("FAIL %s_latency got=%0d exp=%0d", name, lat, exp_lat); end
    end
    checks++; if (O_busy !== 1'b1) begin failures++; $display("FAIL %s_busy got=%b exp=1", name, O_busy); end
    for (int p = 0; p < 42; p++) begin
      if (mode == 1 && p == 11) begin
        I_humi_int = 8'h00; I_humi_dec = 8'h00; I_temp_int = 8'h00; I_temp_dec = 8'h00;
      end
      measure_run(1'b1, lo[p]);
      if (p < 41) begin
        if (mode == 2 && p == 0) begin
          fork
            begin
              repeat (20) @(negedge I_clk);
              host_low = 1'b1;
              repeat (40) @(negedge I_clk);
              host_low = 1'b0;
            end
          join_none
        end
        measure_run(1'b0, hi[p]);
      end
    end
    repeat (2) @(posedge I_clk);
    #1;
    bad_lo = 0; bad_hi = 0; rx = '0; total = 0;
    exp_total = 160 + 160 + 40 * 100 + 100;
    for (int i = 0; i < 40; i++) begin
      if (lo[i + 1] != 100) bad_lo++;
      if (hi[i + 1] != (exp_bits[39 - i] ? 140 : 52)) bad_hi++;
      rx = {rx[38:0], (hi[i + 1] > 100)};
      exp_total += exp_bits[39 - i] ? 140 : 52;
    end
    for (int i = 0; i < 42; i++) total += lo[i];
    for (int i = 0; i < 41; i++) total += hi[i];
    checks++; if (lo[0] != 160) begin failures++; $display("FAIL %s_resp_low got=%0d exp=160", name, lo[0]); end
    checks++; if (hi[0] != 160) begin failures++; $display("FAIL %s_resp_high got=%0d exp=160", name, hi[0]); end
    checks++; if (bad_lo != 0) begin failures++; $display("FAIL %s_bit_low got=%0d_bad exp=0_bad", name, bad_lo); end
    checks++; if (bad_hi != 0) begin failures++; $display("FAIL %s_bit_high got=%0d_bad exp=0_bad", name, bad_hi); end
    checks++; if (lo[41] != 100) begin failures++; $display("FAIL %s_end_low got=%0d exp=100", name, lo[41]); end
    checks++; if (rx[39:32] !== b0) begin failures++; $display("FAIL %s_humi_int got=%h exp=%h", name, rx[39:32], b0); end
    checks++; if (rx[31:24] !== b1) begin failures++; $display("FAIL %s_humi_dec got=%h exp=%h", name, rx[31:24], b1); end
    checks++; if (rx[23:16] !== b2) begin failures++; $display("FAIL %s_temp_int got=%h exp=%h", name, rx[23:16], b2); end
    checks++; if (rx[15:8] !== b3) begin failures++; $display("FAIL %s_temp_dec got=%h exp=%h", name, rx[15:8], b3); end
    checks++; if (rx[7:0] !== exp_ck) begin failures++; $display("FAIL %s_checksum got=%h exp=%h", name, rx[7:0], exp_ck); end
    checks++; if (total != exp_total) begin failures++; $display("FAIL %s_total got=%0d exp=%0d", name, total, exp_total); end
    checks++; if (done_cnt - d0 != 1) begin failures++; $display("FAIL %s_done got=%0d exp=1", name, done_cnt - d0); end
    checks++; if (O_busy !== 1'b0) begin failures++; $display("FAIL %s_busy_end got=%b exp=0", name, O_busy); end
    repeat (20) @(negedge I_clk);
  endtask

  task automatic test_reset_mid_frame;
    int lat, len, d0;
    d0 = done_cnt;
    I_humi_int = 8'h37; I_humi_dec = 8'h00; I_temp_int = 8'h19; I_temp_dec = 8'h05;
    host_start(50);
    wait_oe_high(lat);
    measure_run(1'b1, len);
    measure_run(1'b0, len);
    repeat (30) @(posedge I_clk);
    #1;
    checks++; if (O_sda_oe !== 1'b1) begin failures++; $display("FAIL midrst_in_bit_low got=%b exp=1", O_sda_oe); end
    @(negedge I_clk);
    I_rst_n = 1'b0;
    @(posedge I_clk); #1;
    checks++; if (O_sda_oe !== 1'b0) begin failures++; $display("FAIL midrst_oe got=%b exp=0", O_sda_oe); end
    checks++; if (O_busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", O_busy); end
    @(negedge I_clk);
    I_rst_n = 1'b1;
    repeat (400) @(negedge I_clk);
    checks++; if (done_cnt != d0) begin failures++; $display("FAIL midrst_done got=%0d exp=0", done_cnt - d0); end
    checks++; if (O_sda_oe !== 1'b0) begin failures++; $display("FAIL midrst_idle_oe got=%b exp=0", O_sda_oe); end
  endtask

  initial begin
    test_reset();
    test_reset_mid_frame();
    run_frame("basic", 40, 0, 8'h37, 8'h00, 8'h19, 8'h05, 8'h55, 0);
    test_glitch();
    run_frame("latency", 50, 63, 8'hA5, 8'h3C, 8'h01, 8'h80, 8'h62, 0);
    run_frame("allff", 40, 0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFC, 0);
    run_frame("midchange", 45, 0, 8'h12, 8'h34, 8'h56, 8'h78, 8'h14, 1);
    run_frame("hostnoise", 40, 0, 8'h37, 8'h00, 8'h19, 8'h05, 8'h55, 2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
